fc_mac_engine: RTL and testbench
================================

// Module: fc_mac_engine
// PURPOSE
//  Fully-connected layer engine directly downstream of the pool->FC feature buffer.
//  - On i_fc_start, reads the 384-element int8 feature map 8 lanes per beat.
//  - Reads matching int8 weights and computes NUM_OUT signed dot products.
//  - Streams one accumulator result per output neuron, then pulses o_fc_done.
// PARAMETERS
//  IN_LEN   384  feature elements per neuron; must be a multiple of LANES
//  LANES    8    int8 lanes per beat; fixed by the 64-bit buffer read port
//  NUM_OUT  10   output neurons
//  ACC_W    32   signed accumulator / result width
//  RELU_EN  0    1: negative results are clamped to 0 before output
// PORTS
//  clk           in   1        clock; all logic on posedge
//  rst           in   1        asynchronous, active-high reset
//  i_fc_start    in   1        1-cycle pulse: feature buffer is full and stable
//  o_fc_fm_addr  out  16       feature element address; steps by LANES
//  i_fc_fm_data  in   64       8 x signed int8 features; lane k = bits [8k+7:8k]
//  o_wt_addr     out  16       weight word address = neuron*(IN_LEN/LANES)+beat
//  i_wt_data     in   64       8 x signed int8 weights, same lane order
//  o_fc_valid    out  1        result strobe, one cycle per neuron
//  o_fc_idx      out  8        neuron index of the current o_fc_data
//  o_fc_data     out  ACC_W    signed dot product (ReLU applied if RELU_EN)
//  o_fc_busy     out  1        high from accepted start until o_fc_done
//  o_fc_done     out  1        1-cycle pulse after the last result
// BEHAVIOUR
//  - Reset: every output is 0, FSM is IDLE, and all pipeline valids and accumulators are cleared.
//    Reset mid-run aborts immediately. No partial results or done pulse follow.
//  - Memory timing: both read ports return data exactly 1 cycle after the address is presented.
//    The feature buffer registers its address, so o_fc_fm_addr is held stable for that cycle.
//  - FSM states:
//    IDLE  -> RUN  on i_fc_start. The start pulse is latched and o_fc_busy rises the next cycle.
//    RUN   issues beats b = 0..BEATS-1 (BEATS = IN_LEN/LANES = 48) for neuron n.
//          fm_addr = b*LANES; wt_addr = n*BEATS + b.
//          After beat BEATS-1 it goes to DRAIN; there is no bubble between beats.
//    DRAIN waits 3 cycles for the pipeline to empty.
//          If n < NUM_OUT-1: n++ and return to RUN. Otherwise go to DONE.
//    DONE  pulses o_fc_done for one cycle, deasserts o_fc_busy, and returns to IDLE.
//  - Pipeline stages:
//    S0: address issue.
//    S1: data returns.
//    S2: 8 registered 8x8 signed products, 16 bits each.
//    S3: registered adder-tree sum (19 bits, sign-extended) added to the accumulator.
//        The first beat of a neuron loads the accumulator instead of adding.
//  - Output: o_fc_valid is asserted 4 cycles after the last beat's S0 cycle.
//    o_fc_data and o_fc_idx hold their values until the next valid.
//  - Arithmetic:
//    Worst case is 384*128*128 = 2^22.6, so no overflow is possible at ACC_W >= 24.
//    No saturation; the result is 2's-complement sign-extended to ACC_W.
//  - i_fc_start while busy is ignored. It is neither queued nor restarts the run.
//  - Cycle count per run, start pulse to done pulse: NUM_OUT*(BEATS+3)+2.
//  - When idle, o_fc_fm_addr and o_wt_addr are driven to 0.
// STRUCTURE
//  Shared package fc_pkg:
//    - LANES, IN_LEN, BEATS and ACC_W constants
//    - FSM state enum {IDLE, RUN, DRAIN, DONE}
//    - int8 lane typedef
//  Sub-module fc_mac8:
//    - 8-lane signed multiply (S2) and registered adder tree (S3)
//    - ports: clk, rst, i_valid, i_a[63:0], i_b[63:0], o_valid, o_sum[18:0]
//  Top level holds the FSM, address counters, accumulator, ReLU and output registers.
// TESTING
//  1. All features=1, all weights=1, NUM_OUT=10:
//     10 valids with idx 0..9, each data=384; done pulse at start+10*51+2 cycles.
//  2. Features=-128, weights=-128:
//     every result=6291456 (2^22.6 bound); no wrap at ACC_W=32.
//  3. Features=1, weights for neuron n = -(n) in every lane, RELU_EN=0 then 1:
//     RELU_EN=0 gives data=-384*n; RELU_EN=1 gives data=0 for n>=1.
//  4. Address trace check:
//     fm_addr sequence 0,8,..,376 repeated per neuron; wt_addr runs 0..479 contiguously.
//  5. Second start pulse at cycle 100 of a run:
//     ignored; exactly 10 results and 1 done; busy never drops early.
//  6. rst asserted mid-neuron 3, then a fresh start:
//     all outputs 0 immediately; the new run produces correct idx 0..9 results.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected MAC engine.
package fc_pkg;
   localparam int LANES  = 8;
   localparam int IN_LEN = 384;
   localparam int BEATS  = IN_LEN / LANES;
   localparam int ACC_W  = 32;
   localparam int SUM_W  = 19;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fc_state_e;
   typedef logic signed [7:0] int8_t;
endpackage

// File: rtl/fc_mac8.sv
// 8-lane signed int8 multiply stage followed by a registered adder tree.
module fc_mac8 import fc_pkg::*; (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   input  logic [63:0]             i_a,
   input  logic [63:0]             i_b,
   output logic                    o_valid,
   output logic signed [SUM_W-1:0] o_sum
);
   logic [16*LANES-1:0]     prod_flat;
   logic                    prod_valid_reg;
   logic signed [SUM_W-1:0] tree_sum;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         int8_t              a_lane;
         int8_t              b_lane;
         logic signed [15:0] prod_reg;

         assign a_lane = i_a[8*gi +: 8];
         assign b_lane = i_b[8*gi +: 8];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) prod_reg <= '0;
            else     prod_reg <= a_lane * b_lane;
         end

         assign prod_flat[16*gi +: 16] = prod_reg;
      end
   endgenerate

   // Eight 16-bit products fit in 19 bits including the sign.
   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < LANES; k++)
         tree_sum = tree_sum + SUM_W'(signed'(prod_flat[16*k +: 16]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_valid_reg <= 1'b0;
         o_valid        <= 1'b0;
         o_sum          <= '0;
      end else begin
         prod_valid_reg <= i_valid;
         o_valid        <= prod_valid_reg;
         o_sum          <= tree_sum;
      end
   end
endmodule

// File: rtl/fc_mac_engine.sv
// FC layer engine: sequences feature/weight reads, accumulates one dot
// product per neuron and streams the results.
module fc_mac_engine import fc_pkg::*; #(
   parameter int NUM_OUT = 10,
   parameter bit RELU_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_fc_start,
   output logic [15:0]      o_fc_fm_addr,
   input  logic [63:0]      i_fc_fm_data,
   output logic [15:0]      o_wt_addr,
   input  logic [63:0]      i_wt_data,
   output logic             o_fc_valid,
   output logic [7:0]       o_fc_idx,
   output logic [ACC_W-1:0] o_fc_data,
   output logic             o_fc_busy,
   output logic             o_fc_done
);
   fc_state_e  state_reg, state_next;
   logic [5:0] beat_reg, beat_next;
   logic [7:0] neuron_reg, neuron_next;
   logic [1:0] drain_reg, drain_next;

   logic       s1_valid_reg, s1_first_reg, s1_last_reg;
   logic       s2_first_reg, s2_last_reg;
   logic       s3_first_reg, s3_last_reg;
   logic [7:0] s1_idx_reg, s2_idx_reg, s3_idx_reg;

   logic                    mac_valid;
   logic signed [SUM_W-1:0] mac_sum;
   logic signed [ACC_W-1:0] acc_reg, acc_next, sum_ext, result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         beat_reg   <= '0;
         neuron_reg <= '0;
         drain_reg  <= '0;
         o_fc_busy  <= 1'b0;
         o_fc_done  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         beat_reg   <= beat_next;
         neuron_reg <= neuron_next;
         drain_reg  <= drain_next;
         o_fc_busy  <= (state_next != IDLE);
         o_fc_done  <= (state_reg == DONE);
      end
   end

   always_comb begin
      state_next  = state_reg;
      beat_next   = beat_reg;
      neuron_next = neuron_reg;
      drain_next  = drain_reg;
      case (state_reg)
         IDLE: if (i_fc_start) begin
            state_next  = RUN;
            beat_next   = '0;
            neuron_next = '0;
         end
         RUN: if (beat_reg == 6'(BEATS - 1)) begin
            state_next = DRAIN;
            beat_next  = '0;
            drain_next = '0;
         end else begin
            beat_next = beat_reg + 6'd1;
         end
         DRAIN: if (drain_reg == 2'd2) begin
            if (neuron_reg == 8'(NUM_OUT - 1)) begin
               state_next = DONE;
            end else begin
               state_next  = RUN;
               neuron_next = neuron_reg + 8'd1;
            end
         end else begin
            drain_next = drain_reg + 2'd1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Addresses are only meaningful while issuing beats; zero otherwise.
   always_comb begin
      o_fc_fm_addr = '0;
      o_wt_addr    = '0;
      if (state_reg == RUN) begin
         o_fc_fm_addr = 16'(beat_reg) * 16'(LANES);
         o_wt_addr    = 16'(neuron_reg) * 16'(BEATS) + 16'(beat_reg);
      end
   end

   // Beat tags travel alongside the data so the accumulator knows first/last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_first_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_idx_reg   <= '0;
         s2_first_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s2_idx_reg   <= '0;
         s3_first_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
         s3_idx_reg   <= '0;
      end else begin
         s1_valid_reg <= (state_reg == RUN);
         s1_first_reg <= (beat_reg == '0);
         s1_last_reg  <= (beat_reg == 6'(BEATS - 1));
         s1_idx_reg   <= neuron_reg;
         s2_first_reg <= s1_first_reg;
         s2_last_reg  <= s1_last_reg;
         s2_idx_reg   <= s1_idx_reg;
         s3_first_reg <= s2_first_reg;
         s3_last_reg  <= s2_last_reg;
         s3_idx_reg   <= s2_idx_reg;
      end
   end

   fc_mac8 u_mac8 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (s1_valid_reg),
      .i_a     (i_fc_fm_data),
      .i_b     (i_wt_data),
      .o_valid (mac_valid),
      .o_sum   (mac_sum)
   );

   always_comb begin
      sum_ext  = ACC_W'(mac_sum);
      acc_next = s3_first_reg ? sum_ext : acc_reg + sum_ext;
      result   = acc_next;
      if (RELU_EN && acc_next[ACC_W-1])
         result = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg    <= '0;
         o_fc_valid <= 1'b0;
         o_fc_idx   <= '0;
         o_fc_data  <= '0;
      end else begin
         o_fc_valid <= 1'b0;
         if (mac_valid) begin
            acc_reg <= acc_next;
            if (s3_last_reg) begin
               o_fc_valid <= 1'b1;
               o_fc_idx   <= s3_idx_reg;
               o_fc_data  <= result;
            end
         end
      end
   end
endmodule

// File: tb/tb_fc_mac_engine.sv
// Scoreboard bench: two engines (ReLU off/on) share stimulus; results are
// checked against hand-computed expectations queued per run.
module tb_fc_mac_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;

   logic [15:0] fm_addr0, wt_addr0, fm_addr1, wt_addr1;
   logic [63:0] fm_q0, wt_q0, fm_q1, wt_q1;
   logic        v0, v1, busy0, busy1, done0, done1;
   logic [7:0]  idx0, idx1;
   logic [31:0] data0, data1;

   logic [63:0] fm_mem [48];
   logic [63:0] wt_mem [480];

   typedef struct {
      int     idx;
      longint exp0;
      longint exp1;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fc_mac_engine #(.NUM_OUT(10), .RELU_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .i_fc_start(start),
      .o_fc_fm_addr(fm_addr0), .i_fc_fm_data(fm_q0),
      .o_wt_addr(wt_addr0), .i_wt_data(wt_q0),
      .o_fc_valid(v0), .o_fc_idx(idx0), .o_fc_data(data0),
      .o_fc_busy(busy0), .o_fc_done(done0)
   );

   fc_mac_engine #(.NUM_OUT(10), .RELU_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .i_fc_start(start),
      .o_fc_fm_addr(fm_addr1), .i_fc_fm_data(fm_q1),
      .o_wt_addr(wt_addr1), .i_wt_data(wt_q1),
      .o_fc_valid(v1), .o_fc_idx(idx1), .o_fc_data(data1),
      .o_fc_busy(busy1), .o_fc_done(done1)
   );

   // Registered-read memories: data one cycle after the address.
   always @(posedge clk) begin
      fm_q0 <= fm_mem[fm_addr0[15:3] % 48];
      fm_q1 <= fm_mem[fm_addr1[15:3] % 48];
      wt_q0 <= wt_mem[wt_addr0 % 480];
      wt_q1 <= wt_mem[wt_addr1 % 480];
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (v0 || v1)) begin
         exp_t e;
         check("relu_valid_align", longint'(v1), longint'(v0));
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            check("result_idx", longint'(idx0), longint'(e.idx));
            check("result_idx_relu", longint'(idx1), longint'(e.idx));
            check("result_data", longint'($signed(data0)), e.exp0);
            check("result_data_relu", longint'($signed(data1)), e.exp1);
            $display("result idx=%0d data=%0d relu_data=%0d", idx0, $signed(data0), $signed(data1));
         end
      end
   end

   // mode 0: every weight = w; mode 1: weight = -n; mode 2: lane ramp with neuron-dependent sign
   task automatic load(input logic [63:0] fm_word, input int mode, input logic [7:0] w);
      logic [7:0]  b;
      logic [63:0] word;
      for (int i = 0; i < 48; i++) fm_mem[i] = fm_word;
      for (int n = 0; n < 10; n++) begin
         for (int k = 0; k < 8; k++) begin
            if (mode == 0)      b = w;
            else if (mode == 1) b = 8'(-n);
            else                b = (n % 2 == 0) ? 8'(k - 3) : 8'(3 - k);
            word[8*k +: 8] = b;
         end
         for (int i = 0; i < 48; i++) wt_mem[n*48 + i] = word;
      end
   endtask

   task automatic push(input int n, input longint e0);
      exp_t e;
      e.idx  = n;
      e.exp0 = e0;
      e.exp1 = (e0 < 0) ? 0 : e0;
      sb.push_back(e);
   endtask

   task automatic do_run(input string name, input int abort_k, input int extra_k);
      int busy_err = 0, done_err = 0, valid_err = 0, addr_err = 0;
      int n, r;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 514; k++) begin
         if (k > 1) @(negedge clk);
         start = (k == extra_k);
         if (k == abort_k) begin
            rst = 1'b1;
            sb.delete();
            #1;
            check({name, "_abort_outputs_zero"},
                  longint'({v0, idx0, data0, busy0, done0, fm_addr0, wt_addr0,
                            v1, idx1, data1, busy1, done1}), 0);
            @(negedge clk); rst = 1'b0;
            return;
         end
         n = (k - 1) / 51;
         r = (k - 1) % 51;
         if (busy0 !== (k <= 511) || busy1 !== busy0) busy_err++;
         if (done0 !== (k == 512) || done1 !== done0) done_err++;
         if (v0 !== (k >= 52 && k <= 511 && (k - 52) % 51 == 0)) valid_err++;
         if (k <= 510 && r < 48) begin
            if (fm_addr0 !== 16'(r * 8) || wt_addr0 !== 16'(n * 48 + r)) addr_err++;
         end
      end
      check({name, "_busy_cycles_bad"}, busy_err, 0);
      check({name, "_done_cycles_bad"}, done_err, 0);
      check({name, "_valid_cycles_bad"}, valid_err, 0);
      check({name, "_addr_cycles_bad"}, addr_err, 0);
      $display("run %s complete", name);
   endtask

   initial begin
      #1;
      check("reset_outputs_zero",
            longint'({v0, idx0, data0, busy0, done0, fm_addr0, wt_addr0}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // ones x ones, with a spurious start at cycle 100
      load({8{8'sd1}}, 0, 8'sd1);
      for (int i = 0; i < 10; i++) push(i, 384);
      do_run("ones", 0, 100);

      // extreme operands, no wrap
      load({8{8'h80}}, 0, 8'h80);
      for (int i = 0; i < 10; i++) push(i, 6291456);
      do_run("minmin", 0, 0);

      // negative per-neuron weights, ReLU clamps
      load({8{8'sd1}}, 1, 8'd0);
      for (int i = 0; i < 10; i++) push(i, -384 * i);
      do_run("negw", 0, 0);

      // lane-ordered ramp: sum (k+1)(k-3) = 60 per beat
      load(64'h0807060504030201, 2, 8'd0);
      for (int i = 0; i < 10; i++) push(i, (i % 2 == 0) ? 2880 : -2880);
      do_run("ramp", 0, 0);

      // abort during neuron 3, then a clean rerun
      for (int i = 0; i < 10; i++) push(i, (i % 2 == 0) ? 2880 : -2880);
      do_run("abort", 1 + 51*3 + 10, 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) push(i, (i % 2 == 0) ? 2880 : -2880);
      do_run("rerun", 0, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
